demapping_stream: RTL and testbench
===================================

Name: demapping_stream

Overview:
- Symbol-serial, parametrised successor to the fixed 7-symbol/16-bit flip demapper.
- Collects NSYM received symbols, one per handshake. Each symbol carries a polarity bit, a rotation bit and a flip flag.
- Decodes the frame's flip pattern into a variable-length header code. Packs the pol/rot bits of the non-flipped symbols below that header.
- Presents one (2*NSYM+2)-bit word per frame on a valid/ready output. Sits between the symbol detector and the deframer, and adds illegal-pattern flagging, framing resync and statistics counters.

Parameters:
- NSYM, 7, symbols per frame; legal range 3..11.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- sym_valid  in  1  symbol present
- sym_ready  out  1  symbol accepted when sym_valid&sym_ready
- sym_first  in  1  symbol is index 0 of a frame
- sym_pol  in  1  polarity bit
- sym_rot  in  1  rotation bit
- sym_flip  in  1  flip flag
- out_valid  out  1  decoded word available
- out_ready  in  1  downstream accepts word
- out_data  out  2*NSYM+2  decoded word
- out_nflip  out  2  flip weight of the frame (saturates at 3)
- out_err  out  1  illegal flip pattern
- clr_cnt  in  1  synchronous clear of the statistics counters
- frame_cnt  out  CNT_W  frames delivered, saturating
- err_cnt  out  CNT_W  illegal frames delivered, saturating
- sync_cnt  out  CNT_W  partial frames aborted by sym_first, saturating

Behaviour:
Reset values:
- Synchronous active-low reset clears: symbol index, collection registers, out_valid, out_data, out_nflip, out_err and all counters.
- sym_ready is 1 after reset.

Collection:
- Index idx runs 0..NSYM-1. The accepted symbol is stored at idx; idx then increments.
- Accepting at idx=NSYM-1 completes the frame and wraps idx to 0.
- sym_first=1 on an accepted symbol with idx!=0: discard the partial frame, store this symbol at index 0, set idx=1, increment sync_cnt.
- sym_first=1 at idx=0 is normal. sym_first=0 at idx=0 is accepted (free-running framing).

Decode:
- Flip vector F[NSYM-1:0], weight w.
- w=0: header = 2'b00 in [2N+1:2N].
- w=1, flip at p: header = 4+p, 4 bits in [2N+1:2N-2].
- w=2, flips at i<j: rank r counts pairs ordered by i then j, i.e. (0,1)=0, (0,2)=1, ..., (1,2)=N-1, ... The header is 6 bits, value 4*(4+N)+r, in [2N+1:2N-4].
- Illegal: w>=3, or a w=2 code >63. For NSYM=7 the only illegal w=2 pattern is 7'h60.
- Illegal frames: out_err=1, and the word is generated exactly as for w=1 with p=NSYM-1.
- Data packing: the k-th non-flipped symbol in ascending index goes to out_data[2k]=pol and [2k+1]=rot. The header fills all bits above the data.

Output register and handshake:
- Output register is one-deep. It is loaded in the cycle after the completing symbol is accepted: latency 1.
- out_data, out_nflip and out_err are stable while out_valid&!out_ready.
- sym_ready = !(idx==NSYM-1 && out_valid && !out_ready). Only the completing symbol stalls; a simultaneous drain and load sustains one frame per NSYM cycles with no bubble.
- frame_cnt increments on each out_valid&out_ready. err_cnt increments on the same event when out_err=1.
- All counters saturate at 2^CNT_W-1.
- clr_cnt zeroes the counters and takes priority over any same-cycle increment.
- Reset mid-frame or mid-output drops all state; the next frame starts at idx 0.

Test Plan:
- NSYM=7, pol=1, rot=0 on all symbols, F=7'h00 -> out_data=16'h1555, out_nflip=0, out_err=0, out_valid one cycle after the 7th accept.
- Same pol/rot, F=7'h01 -> 16'h4555, out_nflip=1.
- pol=rot=1, F=7'h05 -> 16'hB7FF; F=7'h50 -> 16'hFFFF; both out_nflip=2, out_err=0.
- pol=1, rot=0, F=7'h60 -> 16'hA555, out_err=1, err_cnt +1. pol=rot=1, F=7'h07 -> 16'hAFFF, out_nflip=3, out_err=1.
- Three symbols then sym_first=1 -> sync_cnt=1; the frame decodes from the new symbol onward. out_ready held 0 for 20 cycles -> sym_ready=0 only at idx 6, no data loss, frame_cnt exact.
- Back-to-back frames with out_ready=1 -> one word per 7 cycles. Assert rst_n=0 mid-frame -> out_valid=0 and counters 0 next cycle. clr_cnt coincident with a delivery -> counters read 0.

Source files
------------

// File: rtl/demapping_stream.sv
// Symbol-serial flip demapper: gathers NSYM symbols, encodes the flip pattern as a
// variable-length header above the packed pol/rot bits of the unflipped symbols.
module demapping_stream #(
  parameter int NSYM  = 7,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic              sym_first,
  input  logic              sym_pol,
  input  logic              sym_rot,
  input  logic              sym_flip,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*NSYM+1:0] out_data,
  output logic [1:0]        out_nflip,
  output logic              out_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  sync_cnt
);

  localparam int                DW        = 2 * NSYM + 2;
  localparam int                IW        = $clog2(NSYM);
  localparam logic [IW-1:0]     LAST_IDX  = IW'(NSYM - 1);
  localparam logic [IW-1:0]     ZERO_IDX  = {IW{1'b0}};
  localparam logic [IW-1:0]     ONE_IDX   = IW'(1);
  localparam logic [7:0]        W2_BASE   = 8'(4 * (4 + NSYM));
  localparam logic [3:0]        ERR_HDR   = 4'(NSYM + 3);
  localparam logic [NSYM-1:0]   LAST_MASK = {1'b1, {(NSYM-1){1'b0}}};
  localparam logic [NSYM-1:0]   NO_MASK   = {NSYM{1'b0}};

  logic [IW-1:0]   idx_r;
  logic [NSYM-1:0] pol_r;
  logic [NSYM-1:0] rot_r;
  logic [NSYM-1:0] flip_r;

  logic [NSYM-1:0] fvec_s;
  logic [NSYM-1:0] pvec_s;
  logic [NSYM-1:0] rvec_s;
  logic [3:0]      wcnt_s;
  logic [3:0]      pos_s;
  logic [6:0]      rank_s;
  logic [7:0]      code2_s;
  logic [DW-1:0]   word_s;
  logic [1:0]      nflip_s;
  logic            err_s;

  logic at_last_s;
  logic accept_s;
  logic resync_s;
  logic complete_s;
  logic drain_s;

  // Packs pol/rot pairs of the symbols not masked by skip, lowest index first.
  function automatic logic [DW-1:0] pack_data(input logic [NSYM-1:0] pol,
                                              input logic [NSYM-1:0] rot,
                                              input logic [NSYM-1:0] skip);
    logic [DW-1:0] d;
    int            k;
    d = {DW{1'b0}};
    k = 0;
    for (int i = 0; i < NSYM; i++) begin
      if (!skip[i]) begin
        d = d | (DW'({rot[i], pol[i]}) << (2 * k));
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign at_last_s  = (idx_r == LAST_IDX);
  assign sym_ready  = !(at_last_s && out_valid && !out_ready);
  assign accept_s   = sym_valid && sym_ready;
  assign resync_s   = accept_s && sym_first && (idx_r != ZERO_IDX);
  assign complete_s = accept_s && at_last_s && !sym_first;
  assign drain_s    = out_valid && out_ready;

  // Frame view with the in-flight completing symbol at NSYM-1; weight, flip position and pair rank.
  always_comb begin
    int r;
    fvec_s = flip_r;
    pvec_s = pol_r;
    rvec_s = rot_r;
    fvec_s[NSYM-1] = sym_flip;
    pvec_s[NSYM-1] = sym_pol;
    rvec_s[NSYM-1] = sym_rot;
    wcnt_s = 4'd0;
    pos_s  = 4'd0;
    rank_s = 7'd0;
    r      = 0;
    for (int i = 0; i < NSYM; i++) begin
      wcnt_s = wcnt_s + {3'b000, fvec_s[i]};
      if (fvec_s[i]) begin
        pos_s = 4'(i);
      end else begin
        pos_s = pos_s;
      end
    end
    // Pairs are enumerated in rank order; only one pair can match when the weight is 2.
    for (int i = 0; i < NSYM - 1; i++) begin
      for (int j = i + 1; j < NSYM; j++) begin
        if (fvec_s[i] && fvec_s[j]) begin
          rank_s = 7'(r);
        end else begin
          rank_s = rank_s;
        end
        r++;
      end
    end
    code2_s = W2_BASE + {1'b0, rank_s};
  end

  // Header selection and word assembly; illegal patterns reuse the single-flip form at NSYM-1.
  always_comb begin
    err_s  = 1'b0;
    word_s = pack_data(pvec_s, rvec_s, NO_MASK);
    case (wcnt_s)
      4'd0: begin
        word_s = pack_data(pvec_s, rvec_s, NO_MASK);
      end
      4'd1: begin
        word_s = pack_data(pvec_s, rvec_s, fvec_s)
               | (DW'(4'd4 + pos_s) << (2 * NSYM - 2));
      end
      4'd2: begin
        if (code2_s > 8'd63) begin
          err_s = 1'b1;
        end else begin
          word_s = pack_data(pvec_s, rvec_s, fvec_s)
                 | (DW'(code2_s[5:0]) << (2 * NSYM - 4));
        end
      end
      default: begin
        err_s = 1'b1;
      end
    endcase
    if (err_s) begin
      word_s = pack_data(pvec_s, rvec_s, LAST_MASK) | (DW'(ERR_HDR) << (2 * NSYM - 2));
    end else begin
      word_s = word_s;
    end
    nflip_s = (wcnt_s > 4'd3) ? 2'd3 : wcnt_s[1:0];
  end

  // Symbol index and collection registers; sym_first mid-frame restarts at index 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r  <= ZERO_IDX;
      pol_r  <= NO_MASK;
      rot_r  <= NO_MASK;
      flip_r <= NO_MASK;
    end else if (resync_s) begin
      pol_r[0]  <= sym_pol;
      rot_r[0]  <= sym_rot;
      flip_r[0] <= sym_flip;
      idx_r     <= ONE_IDX;
    end else if (accept_s) begin
      pol_r[idx_r]  <= sym_pol;
      rot_r[idx_r]  <= sym_rot;
      flip_r[idx_r] <= sym_flip;
      idx_r         <= at_last_s ? ZERO_IDX : idx_r + 1'b1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // One-deep output register; a load may coincide with the drain of the previous word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {DW{1'b0}};
      out_nflip <= 2'd0;
      out_err   <= 1'b0;
    end else if (complete_s) begin
      out_valid <= 1'b1;
      out_data  <= word_s;
      out_nflip <= nflip_s;
      out_err   <= err_s;
    end else if (drain_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Saturating statistics; clear wins over any same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      frame_cnt <= {CNT_W{1'b0}};
      err_cnt   <= {CNT_W{1'b0}};
      sync_cnt  <= {CNT_W{1'b0}};
    end else begin
      frame_cnt <= drain_s ? sat_inc(frame_cnt) : frame_cnt;
      err_cnt   <= (drain_s && out_err) ? sat_inc(err_cnt) : err_cnt;
      sync_cnt  <= resync_s ? sat_inc(sync_cnt) : sync_cnt;
    end
  end

endmodule

// File: tb/tb_demapping_stream.sv
// Self-checking bench for demapping_stream: directed vectors plus randomized frames
// scored against an arithmetic reference model.
module tb_demapping_stream;
  localparam int N    = 7;
  localparam int CW   = 5;
  localparam int DW   = 2 * N + 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0, sym_valid = 1'b0, sym_first = 1'b0;
  logic sym_pol = 1'b0, sym_rot = 1'b0, sym_flip = 1'b0, out_ready = 1'b0, clr_cnt = 1'b0;
  logic sym_ready, out_valid, out_err;
  logic [DW-1:0] out_data;
  logic [1:0]    out_nflip;
  logic [CW-1:0] frame_cnt, err_cnt, sync_cnt;

  typedef struct { logic [DW-1:0] data; logic [1:0] nflip; logic err; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int m_frames = 0, m_errs = 0, m_sync = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;

  demapping_stream #(.NSYM(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_first(sym_first), .sym_pol(sym_pol), .sym_rot(sym_rot), .sym_flip(sym_flip),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nflip(out_nflip), .out_err(out_err), .clr_cnt(clr_cnt),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .sync_cnt(sync_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Reference: header value times 2^(data width) plus base-4 digits of the kept symbols.
  function automatic exp_t model(input logic [N-1:0] f, input logic [N-1:0] pol,
                                 input logic [N-1:0] rot);
    exp_t e;
    int w, i0, j0, p, r, code, hdr, hlen, val, k;
    logic [N-1:0] skip;
    bit bad;
    w = $countones(f); bad = (w >= 3); p = 0; i0 = -1; j0 = 0; code = 0;
    for (int s = 0; s < N; s++) begin
      if (f[s]) begin
        if (i0 < 0) i0 = s; else j0 = s;
        p = s;
      end
    end
    if (w == 2) begin
      r = 0;
      for (int a = 0; a < i0; a++) r += N - 1 - a;
      r += j0 - i0 - 1;
      code = 4 * (4 + N) + r;
      if (code > 63) bad = 1'b1;
    end
    if (bad) begin hdr = 4 + N - 1; hlen = 4; skip = {1'b1, {(N-1){1'b0}}}; end
    else if (w == 0) begin hdr = 0; hlen = 2; skip = {N{1'b0}}; end
    else if (w == 1) begin hdr = 4 + p; hlen = 4; skip = f; end
    else begin hdr = code; hlen = 6; skip = f; end
    val = 0; k = 0;
    for (int s = 0; s < N; s++) begin
      if (!skip[s]) begin
        val += (int'(pol[s]) + 2 * int'(rot[s])) * (4 ** k);
        k++;
      end
    end
    e.data  = DW'(hdr * (2 ** (DW - hlen)) + val);
    e.nflip = (w > 3) ? 2'd3 : 2'(w);
    e.err   = bad;
    return e;
  endfunction

  function automatic logic [N-1:0] rand_flip();
    logic [N-1:0] f;
    int w;
    w = $urandom_range(0, 4);
    if (w == 4) f = N'($urandom);
    else begin
      f = {N{1'b0}};
      while ($countones(f) < w) f[$urandom_range(0, N-1)] = 1'b1;
    end
    return f;
  endfunction

  task automatic send_sym(input logic f, input logic p, input logic r, input logic first);
    int n;
    sym_valid = 1'b1; sym_flip = f; sym_pol = p; sym_rot = r; sym_first = first;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    n = 0;
    while (!sym_ready && n < 40) begin
      if (n >= 3) out_ready = 1'b1;
      @(posedge clk); #2;
      n++;
    end
    chk("sym_accept", sym_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [N-1:0] f, input logic [N-1:0] p,
                            input logic [N-1:0] r, input logic first0, input exp_t e);
    for (int s = 0; s < N; s++) send_sym(f[s], p[s], r[s], (s == 0) ? first0 : 1'b0);
    exp_q.push_back(e);
    chk("latency_valid", out_valid, 1);
    chk("load_word", out_data, e.data);
  endtask

  task automatic idle(input int n);
    sym_valid = 1'b0; sym_first = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_frame_cnt"}, frame_cnt, m_frames);
    chk({tag, "_err_cnt"}, err_cnt, m_errs);
    chk({tag, "_sync_cnt"}, sync_cnt, m_sync);
  endtask

  // Output scoreboard: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_frames = 0; m_errs = 0; m_sync = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_word", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_nflip", out_nflip, e.nflip);
          chk("out_err", out_err, e.err);
        end
      end
      if (clr_cnt) begin
        m_frames = 0; m_errs = 0; m_sync = 0;
      end else if (out_valid && out_ready) begin
        m_frames = sat(m_frames);
        if (out_err) m_errs = sat(m_errs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] d_f [6] = '{7'h00, 7'h01, 7'h05, 7'h50, 7'h60, 7'h07};
    logic [N-1:0] d_r [6] = '{7'h00, 7'h00, 7'h7F, 7'h7F, 7'h00, 7'h7F};
    logic [DW-1:0] d_w [6] = '{16'h1555, 16'h4555, 16'hB7FF, 16'hFFFF, 16'hA555, 16'hAFFF};
    logic [1:0] d_n [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
    logic d_e [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [N-1:0] f, p, r;
    exp_t e, ea, eb;
    int c0, n;

    repeat (3) begin @(posedge clk); #1; end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_nflip", out_nflip, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_sym_ready", sym_ready, 1);
    check_counters("rst");
    rst_n = 1'b1; out_ready = 1'b1;

    for (int i = 0; i < 6; i++) begin
      e.data = d_w[i]; e.nflip = d_n[i]; e.err = d_e[i];
      send_frame(d_f[i], 7'h7F, d_r[i], 1'b1, e);
    end
    idle(2);
    chk("dir_frame_cnt", frame_cnt, 6);
    chk("dir_err_cnt", err_cnt, 2);
    check_counters("dir");

    // Partial frame of three symbols, then a fresh frame marked with sym_first.
    for (int s = 0; s < 3; s++) send_sym($urandom_range(0, 1), 1'b0, 1'b1, (s == 0));
    f = rand_flip(); p = N'($urandom); r = N'($urandom);
    send_frame(f, p, r, 1'b1, model(f, p, r));
    m_sync = sat(m_sync);
    idle(2);
    chk("resync_sync_cnt", sync_cnt, 1);
    check_counters("resync");

    // Backpressure: held word must stay stable and only the completing symbol stalls.
    out_ready = 1'b0;
    f = rand_flip(); p = N'($urandom); r = N'($urandom);
    ea = model(f, p, r);
    send_frame(f, p, r, 1'b1, ea);
    f = rand_flip(); p = N'($urandom); r = N'($urandom);
    eb = model(f, p, r);
    for (int s = 0; s < N - 1; s++) begin
      chk("stall_mid_ready", sym_ready, 1);
      send_sym(f[s], p[s], r[s], (s == 0));
    end
    sym_valid = 1'b1; sym_flip = f[N-1]; sym_pol = p[N-1]; sym_rot = r[N-1]; sym_first = 1'b0;
    #1;
    for (int c = 0; c < 20; c++) begin
      chk("stall_ready_low", sym_ready, 0);
      chk("stall_hold_data", out_data, ea.data);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release", sym_ready, 1);
    @(posedge clk); #1;
    exp_q.push_back(eb);
    chk("stall_load_valid", out_valid, 1);
    chk("stall_load_data", out_data, eb.data);
    idle(2);
    check_counters("stall");

    // Back-to-back frames: one word per N cycles.
    c0 = cyc;
    for (int i = 0; i < 3; i++) begin
      f = rand_flip(); p = N'($urandom); r = N'($urandom);
      send_frame(f, p, r, 1'b1, model(f, p, r));
    end
    chk("throughput_cycles", cyc - c0, 3 * N);
    idle(2);

    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      f = rand_flip(); p = N'($urandom); r = N'($urandom);
      send_frame(f, p, r, 1'b1, model(f, p, r));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    rand_ready = 1'b0; out_ready = 1'b1;
    idle(1);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain_empty", exp_q.size(), 0);
    check_counters("rand");
    chk("frame_cnt_sat", frame_cnt, CMAX);

    // Clear coincident with a delivery.
    f = rand_flip(); p = N'($urandom); r = N'($urandom);
    send_frame(f, p, r, 1'b1, model(f, p, r));
    sym_valid = 1'b0; clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_frame_cnt", frame_cnt, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_sync_cnt", sync_cnt, 0);
    f = rand_flip(); p = N'($urandom); r = N'($urandom);
    send_frame(f, p, r, 1'b1, model(f, p, r));
    idle(2);
    chk("post_clr_frame_cnt", frame_cnt, 1);
    check_counters("post_clr");

    // Reset with a word pending and a partial frame collected.
    out_ready = 1'b0;
    f = rand_flip(); p = N'($urandom); r = N'($urandom);
    send_frame(f, p, r, 1'b1, model(f, p, r));
    for (int s = 0; s < 3; s++) send_sym(1'b0, 1'b1, 1'b1, (s == 0));
    rst_n = 1'b0; sym_valid = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk("mid_rst_sync_cnt", sync_cnt, 0);
    chk("mid_rst_sym_ready", sym_ready, 1);
    rst_n = 1'b1; out_ready = 1'b1;
    f = rand_flip(); p = N'($urandom); r = N'($urandom);
    send_frame(f, p, r, 1'b0, model(f, p, r));
    idle(3);
    chk("final_drain", exp_q.size(), 0);
    check_counters("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
